// File: rtl/spi_pkg.sv
// Shared SPI definitions for the master and slave ends of the link.
package spi_pkg;

    localparam int unsigned SPI_DATA_W      = 8;
    localparam int unsigned SPI_FRAME_EDGES = 16;
    localparam int unsigned SPI_DIV_W       = 16;
    localparam int unsigned SPI_EDGE_W      = 5;

    // EDGE is a transient step for the master: its edge action fires on the tick ending SETUP/WAIT.
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SETUP = 3'd1,
        EDGE  = 3'd2,
        WAIT  = 3'd3,
        LAST  = 3'd4,
        ACK   = 3'd5
    } spi_state_e;

    // Odd edge counts are the leading SCLK edge of a bit cell.
    function automatic logic is_lead_edge(input logic [SPI_EDGE_W-1:0] edge_cnt);
        return edge_cnt[0];
    endfunction

endpackage

// File: rtl/spi_clk_div.sv
// Half-period timer: tick_c is high for one cycle every div_q+1 cycles after a start strobe.
module spi_clk_div
    import spi_pkg::*;
(
    input  logic                 sys_clk,
    input  logic                 sys_rst,
    input  logic                 start,
    input  logic [SPI_DIV_W-1:0] div_q,
    output logic                 tick_c
);

    logic [SPI_DIV_W-1:0] cnt_q;

    // Counter wraps at div_q, so even div_q = 0xFFFF never overflows.
    assign tick_c = (cnt_q == div_q);

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            cnt_q <= '0;
        end else if (start || tick_c) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + SPI_DIV_W'(1);
        end
    end

endmodule

// File: rtl/spi_master.sv
// Byte-wide full-duplex SPI master, MSB first, programmable SCLK half-period.
module spi_master
    import spi_pkg::*;
#(
    parameter logic CPOL = 1'b1,
    parameter logic CPHA = 1'b1
) (
    input  logic                  sys_clk,
    input  logic                  sys_rst,
    input  logic                  wr_req,
    input  logic [SPI_DATA_W-1:0] data_tx,
    input  logic [SPI_DIV_W-1:0]  clk_div_val,
    output logic                  wr_ack,
    output logic                  busy,
    output logic [SPI_DATA_W-1:0] data_rx,
    output logic                  cs,
    output logic                  sclk,
    output logic                  mosi,
    input  logic                  miso
);

    spi_state_e             state_q, state_d;
    logic [SPI_DATA_W-1:0]  tx_q, tx_d;
    logic [SPI_DATA_W-1:0]  rx_q, rx_d;
    logic [SPI_DATA_W-1:0]  data_rx_q, data_rx_d;
    logic [SPI_DIV_W-1:0]   div_q, div_d;
    logic [SPI_EDGE_W-1:0]  edge_q, edge_d, edge_n_c;
    logic                   sclk_q, sclk_d;
    logic                   cs_q, cs_d;
    logic                   busy_q, busy_d;
    logic                   ack_q, ack_d;
    logic                   start_c;
    logic                   tick_c;
    logic                   lead_c;
    logic                   miso_meta, miso_s;

    spi_clk_div u_clk_div (
        .sys_clk (sys_clk),
        .sys_rst (sys_rst),
        .start   (start_c),
        .div_q   (div_q),
        .tick_c  (tick_c)
    );

    // miso is asynchronous to sys_clk.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            miso_meta <= 1'b0;
            miso_s    <= 1'b0;
        end else begin
            miso_meta <= miso;
            miso_s    <= miso_meta;
        end
    end

    assign edge_n_c = edge_q + SPI_EDGE_W'(1);
    assign lead_c   = is_lead_edge(edge_n_c);

    always_comb begin
        state_d   = state_q;
        tx_d      = tx_q;
        rx_d      = rx_q;
        data_rx_d = data_rx_q;
        div_d     = div_q;
        edge_d    = edge_q;
        sclk_d    = sclk_q;
        cs_d      = cs_q;
        busy_d    = busy_q;
        ack_d     = 1'b0;
        start_c   = 1'b0;

        case (state_q)
            // ACK doubles as the first idle cycle so a held wr_req restarts with one cycle of cs high.
            IDLE, ACK: begin
                if (wr_req) begin
                    tx_d    = data_tx;
                    div_d   = clk_div_val;
                    rx_d    = '0;
                    edge_d  = '0;
                    cs_d    = 1'b0;
                    busy_d  = 1'b1;
                    start_c = 1'b1;
                    state_d = SETUP;
                end else begin
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end
            end
            SETUP, WAIT: begin
                if (tick_c) begin
                    edge_d = edge_n_c;
                    sclk_d = ~sclk_q;
                    if (lead_c != CPHA) begin
                        rx_d = {rx_q[SPI_DATA_W-2:0], miso_s};
                    end else if ((edge_n_c != SPI_EDGE_W'(1)) &&
                                 (edge_n_c != SPI_EDGE_W'(SPI_FRAME_EDGES))) begin
                        tx_d = {tx_q[SPI_DATA_W-2:0], 1'b0};
                    end
                    state_d = (edge_n_c == SPI_EDGE_W'(SPI_FRAME_EDGES)) ? LAST : WAIT;
                end
            end
            LAST: begin
                if (tick_c) begin
                    cs_d      = 1'b1;
                    ack_d     = 1'b1;
                    data_rx_d = rx_q;
                    state_d   = ACK;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state_q   <= IDLE;
            tx_q      <= '0;
            rx_q      <= '0;
            data_rx_q <= '0;
            div_q     <= '0;
            edge_q    <= '0;
            sclk_q    <= CPOL;
            cs_q      <= 1'b1;
            busy_q    <= 1'b0;
            ack_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            tx_q      <= tx_d;
            rx_q      <= rx_d;
            data_rx_q <= data_rx_d;
            div_q     <= div_d;
            edge_q    <= edge_d;
            sclk_q    <= sclk_d;
            cs_q      <= cs_d;
            busy_q    <= busy_d;
            ack_q     <= ack_d;
        end
    end

    assign wr_ack  = ack_q;
    assign busy    = busy_q;
    assign data_rx = data_rx_q;
    assign cs      = cs_q;
    assign sclk    = sclk_q;
    assign mosi    = tx_q[SPI_DATA_W-1];

endmodule

// File: tb/tb_spi_master.sv
// Directed bench for spi_master: mode 3 loopback instance and mode 0 instance against a behavioral slave.
module tb_spi_master;

    logic        sys_clk;
    logic        sys_rst;

    // Mode 3 instance, mosi looped back to miso
    logic        wr_req_a;
    logic [7:0]  data_tx_a;
    logic [15:0] div_a;
    logic        wr_ack_a, busy_a, cs_a, sclk_a, mosi_a, miso_a;
    logic [7:0]  data_rx_a;

    // Mode 0 instance, behavioral slave
    logic        wr_req_b;
    logic [7:0]  data_tx_b;
    logic [15:0] div_b;
    logic        wr_ack_b, busy_b, cs_b, sclk_b, mosi_b, miso_b;
    logic [7:0]  data_rx_b;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int ack_cnt_a = 0;
    int tog_b  = 0;
    int sl_fall = 0;
    int sl_base = 0;
    int ack_base;
    int tog_base;
    logic [7:0] sl_byte = 8'h00;
    logic [7:0] sl_rx;
    logic [7:0] exp_byte;

    spi_master #(.CPOL(1'b1), .CPHA(1'b1)) dut_a (
        .sys_clk     (sys_clk),
        .sys_rst     (sys_rst),
        .wr_req      (wr_req_a),
        .data_tx     (data_tx_a),
        .clk_div_val (div_a),
        .wr_ack      (wr_ack_a),
        .busy        (busy_a),
        .data_rx     (data_rx_a),
        .cs          (cs_a),
        .sclk        (sclk_a),
        .mosi        (mosi_a),
        .miso        (miso_a)
    );

    spi_master #(.CPOL(1'b0), .CPHA(1'b0)) dut_b (
        .sys_clk     (sys_clk),
        .sys_rst     (sys_rst),
        .wr_req      (wr_req_b),
        .data_tx     (data_tx_b),
        .clk_div_val (div_b),
        .wr_ack      (wr_ack_b),
        .busy        (busy_b),
        .data_rx     (data_rx_b),
        .cs          (cs_b),
        .sclk        (sclk_b),
        .mosi        (mosi_b),
        .miso        (miso_b)
    );

    initial begin
        sys_clk = 1'b0;
        forever #5 sys_clk = ~sys_clk;
    end

    assign miso_a = mosi_a;

    // Mode 0 slave: captures mosi on rising sclk, advances its output bit on falling sclk.
    always @(posedge sclk_b) if (!cs_b) sl_rx <= {sl_rx[6:0], mosi_b};
    always @(negedge sclk_b) sl_fall <= sl_fall + 1;
    always @(posedge sclk_b or negedge sclk_b) tog_b <= tog_b + 1;
    assign miso_b = ((sl_fall - sl_base) < 8) ? sl_byte[3'(7 - (sl_fall - sl_base))] : 1'b0;

    always @(posedge sys_clk) if (wr_ack_a) ack_cnt_a <= ack_cnt_a + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge sys_clk);
        #1;
        cyc++;
    endtask

    task automatic goto(input int c);
        while (cyc < c) step();
    endtask

    initial begin
        sys_rst   = 1'b1;
        wr_req_a  = 1'b0; data_tx_a = 8'h00; div_a = 16'h0000;
        wr_req_b  = 1'b0; data_tx_b = 8'h00; div_b = 16'h0000;
        #2;
        check("rst_cs",      32'(cs_a),      32'h1);
        check("rst_sclk_a",  32'(sclk_a),    32'h1);
        check("rst_sclk_b",  32'(sclk_b),    32'h0);
        check("rst_mosi",    32'(mosi_a),    32'h0);
        check("rst_wr_ack",  32'(wr_ack_a),  32'h0);
        check("rst_busy",    32'(busy_a),    32'h0);
        check("rst_data_rx", 32'(data_rx_a), 32'h0);
        step(); step();
        sys_rst = 1'b0;
        step();

        // Mode 3 loopback, H=4
        data_tx_a = 8'hA5; div_a = 16'd3; wr_req_a = 1'b1; cyc = 0;
        step();
        wr_req_a = 1'b0;
        check("m3_cs_low", 32'(cs_a),   32'h0);
        check("m3_busy",   32'(busy_a), 32'h1);
        exp_byte = 8'hA5;
        for (int k = 1; k <= 15; k += 2) begin
            goto(1 + 4 * k);
            check("m3_sclk_fall", 32'(sclk_a), 32'h0);
            check("m3_mosi_bit",  32'(mosi_a), 32'(exp_byte[3'(7 - (k - 1) / 2)]));
        end
        goto(68);
        check("m3_no_early_ack", 32'(wr_ack_a), 32'h0);
        goto(69);
        check("m3_wr_ack",  32'(wr_ack_a),  32'h1);
        check("m3_data_rx", 32'(data_rx_a), 32'hA5);
        check("m3_cs_high", 32'(cs_a),      32'h1);
        check("m3_sclk_idle", 32'(sclk_a),  32'h1);
        goto(70);
        check("m3_ack_pulse", 32'(wr_ack_a), 32'h0);
        check("m3_busy_low",  32'(busy_a),   32'h0);
        check("m3_rx_hold",   32'(data_rx_a), 32'hA5);

        // Mode 0 against behavioral slave, H=5
        sl_byte = 8'h3C; sl_base = sl_fall; tog_base = tog_b;
        data_tx_b = 8'hC3; div_b = 16'd4; wr_req_b = 1'b1; cyc = 0;
        step();
        wr_req_b = 1'b0;
        check("m0_cs_low", 32'(cs_b), 32'h0);
        goto(85);
        check("m0_no_early_ack", 32'(wr_ack_b), 32'h0);
        goto(86);
        check("m0_wr_ack",     32'(wr_ack_b),  32'h1);
        check("m0_data_rx",    32'(data_rx_b), 32'h3C);
        check("m0_slave_rx",   32'(sl_rx),     32'hC3);
        check("m0_toggles",    32'(tog_b - tog_base), 32'd16);
        check("m0_sclk_at_cs", 32'(sclk_b),    32'h0);
        check("m0_cs_high",    32'(cs_b),      32'h1);
        step();

        // Minimum divider, H=1
        data_tx_a = 8'h5A; div_a = 16'd0; wr_req_a = 1'b1; cyc = 0;
        step();
        wr_req_a = 1'b0;
        check("min_sclk_c1", 32'(sclk_a), 32'h1);
        for (int c = 2; c <= 17; c++) begin
            goto(c);
            check("min_sclk_toggle", 32'(sclk_a), (c % 2 == 0) ? 32'h0 : 32'h1);
        end
        goto(18);
        check("min_wr_ack",  32'(wr_ack_a), 32'h1);
        check("min_busy_18", 32'(busy_a),   32'h1);
        goto(19);
        check("min_busy_19", 32'(busy_a),   32'h0);
        step();

        // Request while busy is ignored
        ack_base = ack_cnt_a;
        data_tx_a = 8'h12; div_a = 16'd3; wr_req_a = 1'b1; cyc = 0;
        step();
        wr_req_a = 1'b0;
        goto(20);
        data_tx_a = 8'hFF; div_a = 16'd0; wr_req_a = 1'b1;
        step();
        wr_req_a = 1'b0;
        goto(69);
        check("rwb_wr_ack",  32'(wr_ack_a),  32'h1);
        check("rwb_data_rx", 32'(data_rx_a), 32'h12);
        goto(150);
        check("rwb_one_ack", 32'(ack_cnt_a - ack_base), 32'd1);
        check("rwb_idle_cs", 32'(cs_a),   32'h1);
        check("rwb_idle_busy", 32'(busy_a), 32'h0);

        // Back-to-back frames with wr_req held
        ack_base = ack_cnt_a;
        data_tx_a = 8'h01; div_a = 16'd3; wr_req_a = 1'b1; cyc = 0;
        step();
        data_tx_a = 8'h80;
        goto(68);
        check("b2b_cs_low_68", 32'(cs_a), 32'h0);
        goto(69);
        check("b2b_ack1",    32'(wr_ack_a),  32'h1);
        check("b2b_rx1",     32'(data_rx_a), 32'h01);
        check("b2b_cs_gap",  32'(cs_a),      32'h1);
        goto(70);
        wr_req_a = 1'b0;
        check("b2b_cs_low_70", 32'(cs_a),   32'h0);
        check("b2b_busy_70",   32'(busy_a), 32'h1);
        goto(138);
        check("b2b_ack2",  32'(wr_ack_a),  32'h1);
        check("b2b_rx2",   32'(data_rx_a), 32'h80);
        goto(139);
        check("b2b_busy_low", 32'(busy_a), 32'h0);
        check("b2b_two_acks", 32'(ack_cnt_a - ack_base), 32'd2);

        // Reset mid-frame after edge 7
        data_tx_a = 8'h5A; div_a = 16'd3; wr_req_a = 1'b1; cyc = 0;
        step();
        wr_req_a = 1'b0;
        goto(30);
        check("rmf_mid_cs", 32'(cs_a), 32'h0);
        #3;
        sys_rst = 1'b1;
        #1;
        check("rmf_cs",      32'(cs_a),      32'h1);
        check("rmf_sclk",    32'(sclk_a),    32'h1);
        check("rmf_busy",    32'(busy_a),    32'h0);
        check("rmf_data_rx", 32'(data_rx_a), 32'h0);
        ack_base = ack_cnt_a;
        step(); step();
        sys_rst = 1'b0;
        goto(120);
        check("rmf_no_ack", 32'(ack_cnt_a - ack_base), 32'd0);
        data_tx_a = 8'h3C; div_a = 16'd3; wr_req_a = 1'b1; cyc = 0;
        step();
        wr_req_a = 1'b0;
        goto(69);
        check("rmf_next_ack", 32'(wr_ack_a),  32'h1);
        check("rmf_next_rx",  32'(data_rx_a), 32'h3C);
        step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
